// File: rtl/johnson_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | johnson_pkg                                                                |
// | Shared Johnson-code types and decode helpers for codes up to 64 bits.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package johnson_pkg;

    localparam int c_MAX_W  = 64;
    localparam int c_IDXF_W = 7;

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCK   = 2'd2
    } lock_state_e;

    // A legal word has at most one transition between adjacent bits.
    function automatic logic johnson_legal(input logic [c_MAX_W-1:0] code, input int width);
        logic [c_IDXF_W-1:0] trans;
        trans = '0;
        for (int i = 0; i < c_MAX_W - 1; i++) begin
            if ((i < width - 1) && (code[i] != code[i+1])) begin
                trans = trans + c_IDXF_W'(1);
            end
        end
        return (trans <= c_IDXF_W'(1));
    endfunction

    function automatic logic [c_IDXF_W-1:0] johnson_idx(input logic [c_MAX_W-1:0] code, input int width);
        logic [c_IDXF_W-1:0] pc;
        pc = '0;
        for (int i = 0; i < c_MAX_W; i++) begin
            if (i < width) begin
                pc = pc + c_IDXF_W'(code[i]);
            end
        end
        if (code[0] || (code == '0)) begin
            return pc;
        end
        return c_IDXF_W'(2 * width) - pc;
    endfunction

    function automatic logic [c_IDXF_W-1:0] johnson_succ(input logic [c_IDXF_W-1:0] idx, input int width);
        if (idx == c_IDXF_W'(2 * width - 1)) begin
            return '0;
        end
        return idx + c_IDXF_W'(1);
    endfunction

endpackage : johnson_pkg
`default_nettype wire

// File: rtl/johnson_code_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | johnson_code_check                                                         |
// | Combinational legality check and binary decode of a Johnson code word.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] code_i,
    output logic             legal_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [c_MAX_W-1:0]  w_code_ext;
    logic [c_IDXF_W-1:0] w_idx_full;

    assign w_code_ext = c_MAX_W'(code_i);
    assign w_idx_full = johnson_idx(w_code_ext, WIDTH);
    assign legal_o    = johnson_legal(w_code_ext, WIDTH);
    assign idx_o      = w_idx_full[IDX_W-1:0];

endmodule : johnson_code_check
`default_nettype wire

// File: rtl/johnson_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | johnson_decoder                                                            |
// | Registered Johnson decode with step checking, lock tracking, error count.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int IDX_W  = $clog2(2 * WIDTH),
    parameter int LOCK_N = 4,
    parameter int ERRC_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid_i,
    input  logic [WIDTH-1:0]  code_i,
    output logic              idx_valid_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              illegal_o,
    output logic              step_err_o,
    output logic              wrap_o,
    output logic              locked_o,
    output logic [ERRC_W-1:0] err_count_o
);

    localparam int               CNT_W     = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] c_LOCK_N  = CNT_W'(LOCK_N);
    localparam logic [IDX_W-1:0] c_MAX_IDX = IDX_W'(2 * WIDTH - 1);

    logic                w_legal;
    logic [IDX_W-1:0]    w_idx;
    logic [c_IDXF_W-1:0] w_succ;
    logic                w_step;
    logic                w_wrap;
    logic                w_err;

    logic                idx_valid_q;
    logic [IDX_W-1:0]    idx_q;
    logic                illegal_q;
    logic                step_err_q;
    logic                wrap_q;
    logic                have_prev_q;
    logic [ERRC_W-1:0]   err_count_q;
    lock_state_e         state_q, state_d;
    logic [CNT_W-1:0]    good_cnt_q, good_cnt_d;

    johnson_code_check #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_check (
        .code_i  (code_i),
        .legal_o (w_legal),
        .idx_o   (w_idx)
    );

    // idx_q doubles as the previous-index register: both update only on legal samples.
    assign w_succ = johnson_succ(c_IDXF_W'(idx_q), WIDTH);
    assign w_step = have_prev_q && w_legal && (c_IDXF_W'(w_idx) != w_succ);
    assign w_wrap = have_prev_q && w_legal && !w_step && (idx_q == c_MAX_IDX) && (w_idx == '0);
    assign w_err  = !w_legal || w_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_valid_q <= 1'b0;
            idx_q       <= '0;
            illegal_q   <= 1'b0;
            step_err_q  <= 1'b0;
            wrap_q      <= 1'b0;
            have_prev_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            idx_valid_q <= code_valid_i;
            illegal_q   <= code_valid_i && !w_legal;
            step_err_q  <= code_valid_i && w_step;
            wrap_q      <= code_valid_i && w_wrap;
            if (code_valid_i) begin
                have_prev_q <= w_legal;
                if (w_legal) begin
                    idx_q <= w_idx;
                end
                if (w_err && (err_count_q != '1)) begin
                    err_count_q <= err_count_q + ERRC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_UNLOCK;
            good_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        if (code_valid_i) begin
            case (state_q)
                ST_UNLOCK: begin
                    if (w_legal) begin
                        state_d    = ST_ACQ;
                        good_cnt_d = '0;
                    end
                end
                ST_ACQ: begin
                    if (w_err) begin
                        state_d    = ST_UNLOCK;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + CNT_W'(1);
                        if (good_cnt_d == c_LOCK_N) begin
                            state_d = ST_LOCK;
                        end
                    end
                end
                ST_LOCK: begin
                    if (w_err) begin
                        state_d    = ST_UNLOCK;
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = ST_UNLOCK;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked_o = (state_q == ST_LOCK);
    end

    assign idx_valid_o = idx_valid_q;
    assign idx_o       = idx_q;
    assign illegal_o   = illegal_q;
    assign step_err_o  = step_err_q;
    assign wrap_o      = wrap_q;
    assign err_count_o = err_count_q;

endmodule : johnson_decoder
`default_nettype wire

// File: tb/tb_johnson_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_johnson_decoder                                                         |
// | Directed self-checking bench for johnson_decoder at WIDTH=32.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_johnson_decoder;

    logic        clk;
    logic        reset;
    logic        code_valid;
    logic [31:0] code;

    logic        idx_valid, illegal, step_err, wrap, locked;
    logic [5:0]  idx;
    logic [15:0] err_count;

    logic        idx_valid4, illegal4, step_err4, wrap4, locked4;
    logic [5:0]  idx4;
    logic [3:0]  err_count4;

    int checks = 0;
    int errors = 0;

    johnson_decoder #(.WIDTH(32), .IDX_W(6), .LOCK_N(4), .ERRC_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .code_valid_i (code_valid),
        .code_i       (code),
        .idx_valid_o  (idx_valid),
        .idx_o        (idx),
        .illegal_o    (illegal),
        .step_err_o   (step_err),
        .wrap_o       (wrap),
        .locked_o     (locked),
        .err_count_o  (err_count)
    );

    johnson_decoder #(.WIDTH(32), .IDX_W(6), .LOCK_N(4), .ERRC_W(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .code_valid_i (code_valid),
        .code_i       (code),
        .idx_valid_o  (idx_valid4),
        .idx_o        (idx4),
        .illegal_o    (illegal4),
        .step_err_o   (step_err4),
        .wrap_o       (wrap4),
        .locked_o     (locked4),
        .err_count_o  (err_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Johnson word for a given index at WIDTH=32, built by shifting rather than decoding.
    function automatic logic [31:0] jword(input int i);
        logic [63:0] w;
        if (i <= 32) w = (64'd1 << i) - 64'd1;
        else         w = 64'hFFFF_FFFF << (i - 32);
        return w[31:0];
    endfunction

    // Inputs change at a falling edge; the result is visible at the next falling edge.
    task automatic drive(input logic v, input logic [31:0] c);
        code_valid = v;
        code       = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0);
        drive(1'b0, 32'h0);
        reset = 1'b0;
    endtask

    int base_err;

    initial begin
        reset      = 1'b1;
        code_valid = 1'b0;
        code       = '0;
        @(negedge clk);
        do_reset();

        chk("rst_idx_valid", idx_valid, 0);
        chk("rst_idx", idx, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_step_err", step_err, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err_count", err_count, 0);

        // Clean sequence 1..63,0..6
        for (int i = 0; i < 70; i++) begin
            drive(1'b1, jword((1 + i) % 64));
            chk("seq_valid", idx_valid, 1);
            chk("seq_idx", idx, (1 + i) % 64);
            chk("seq_illegal", illegal, 0);
            chk("seq_step", step_err, 0);
            chk("seq_wrap", wrap, ((1 + i) % 64) == 0);
            chk("seq_locked", locked, i >= 4);
        end
        drive(1'b0, 32'h0);
        chk("idle_valid", idx_valid, 0);
        chk("idle_idx_hold", idx, 6);
        chk("idle_locked", locked, 1);
        chk("seq_err_count", err_count, 0);

        // Decode boundary words with out-of-sequence steps
        do_reset();
        drive(1'b1, 32'h0000_0000);
        chk("zero_idx", idx, 0);
        chk("zero_step", step_err, 0);
        drive(1'b1, 32'hFFFF_FFFF);
        chk("ones_idx", idx, 32);
        chk("ones_step", step_err, 1);
        chk("ones_illegal", illegal, 0);
        drive(1'b1, 32'h8000_0000);
        chk("top_idx", idx, 63);
        chk("top_step", step_err, 1);
        drive(1'b0, 32'h0);
        chk("bnd_err_count", err_count, 2);

        // Illegal word mid-sequence clears the step history
        do_reset();
        for (int i = 1; i <= 10; i++) drive(1'b1, jword(i));
        chk("pre_ill_locked", locked, 1);
        drive(1'b1, 32'h0000_0505);
        chk("ill_flag", illegal, 1);
        chk("ill_idx_hold", idx, 10);
        chk("ill_step", step_err, 0);
        chk("ill_locked", locked, 0);
        drive(1'b1, jword(11));
        chk("post_ill_idx", idx, 11);
        chk("post_ill_step", step_err, 0);
        chk("post_ill_illegal", illegal, 0);
        chk("post_ill_locked", locked, 0);
        chk("ill_err_count", err_count, 1);

        // Skip while locked, then reacquire
        do_reset();
        for (int i = 1; i <= 20; i++) drive(1'b1, jword(i));
        chk("skip_pre_locked", locked, 1);
        base_err = int'(err_count);
        drive(1'b1, jword(22));
        chk("skip_step", step_err, 1);
        chk("skip_idx", idx, 22);
        chk("skip_locked", locked, 0);
        chk("skip_err_count", err_count, 64'(base_err + 1));
        drive(1'b1, jword(23));
        chk("reacq_first_locked", locked, 0);
        chk("reacq_first_step", step_err, 0);
        for (int i = 24; i <= 27; i++) drive(1'b1, jword(i));
        chk("reacq_locked", locked, 1);
        chk("reacq_idx", idx, 27);

        // Reset in the middle of a valid stream
        do_reset();
        for (int i = 30; i <= 40; i++) drive(1'b1, jword(i));
        chk("pre_rst_idx", idx, 40);
        reset = 1'b1;
        drive(1'b1, jword(41));
        chk("mid_rst_valid", idx_valid, 0);
        chk("mid_rst_idx", idx, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_wrap", wrap, 0);
        reset = 1'b0;
        drive(1'b1, jword(5));
        chk("after_rst_idx", idx, 5);
        chk("after_rst_step", step_err, 0);
        chk("after_rst_err", err_count, 0);

        // Error counter saturation on the 4-bit instance
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 32'h0000_0505);
            if (i == 14) chk("sat_err4_14", err_count4, 4'hE);
            if (i == 15) chk("sat_err4_15", err_count4, 4'hF);
        end
        chk("sat_err4_final", err_count4, 4'hF);
        chk("sat_illegal4", illegal4, 1);
        chk("sat_err16_final", err_count, 20);
        drive(1'b0, 32'h0);
        chk("sat_err4_hold", err_count4, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_johnson_decoder
`default_nettype wire
